// File: rtl/fb_access_scheduler.sv
// fb_access_scheduler: single arbitration point for SDRAM frame-buffer line fetches,
// pixel writes and auto-refresh, with a one-deep write holding register.
// Refresh timer and REF_* states are built only when FB_SCHED_REFRESH_EN is defined.
module fb_access_scheduler #(
  parameter int unsigned REFRESH_INTERVAL = 1000,
  parameter int unsigned STARVE_LIMIT     = 4,
  parameter int unsigned TIMEOUT          = 4096,
  localparam int unsigned DataW           = 40
) (
  input  logic             clk133,
  input  logic             rstn,
  input  logic             line_req,
  output logic             line_ack,
  input  logic             wr_valid,
  input  logic [DataW-1:0] wr_data,
  output logic             wr_ready,
  output logic             wr_drop,
  output logic             fb_requestNewLine,
  output logic             fb_requestNewWrite,
  output logic             fb_requestRefresh,
  output logic [DataW-1:0] fb_writeData,
  input  logic             fb_readBusy,
  input  logic             fb_writeBusy,
  input  logic             fb_refreshBusy,
  output logic             refresh_overdue,
  output logic             timeout_err
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned ToW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LINE_ISSUE,
    LINE_WAIT_DONE,
    WR_ISSUE,
    WR_WAIT_DONE
`ifdef FB_SCHED_REFRESH_EN
    , REF_ISSUE,
    REF_WAIT_DONE
`endif
  } state_e;

  state_e             state_q, state_d;
  logic               hold_valid_q, hold_valid_d;
  logic [DataW-1:0]   wdata_q, wdata_d;
  logic               wr_ready_q, wr_ready_d;
  logic               wr_drop_q, wr_drop_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [ToW-1:0]     to_cnt_q, to_cnt_d;
  logic               req_line_q, req_line_d;
  logic               req_wr_q, req_wr_d;
  logic               line_ack_q, line_ack_d;
  logic               timeout_err_q, timeout_err_d;
  logic               all_idle_c, starve_hit_c, to_hit_c, mode_ok_c;
  logic               grant_line_c, grant_wr_c, line_done_c, wr_done_c, timed_out_c;

`ifdef FB_SCHED_REFRESH_EN
  localparam int unsigned RefW = $clog2(REFRESH_INTERVAL + 1);
  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic            ref_pending_q, ref_pending_d;
  logic            overdue_q, overdue_d;
  logic            req_ref_q, req_ref_d;
  logic            ref_expire_c;

  assign all_idle_c = !fb_readBusy && !fb_writeBusy && !fb_refreshBusy;
`else
  logic unused_ref_c;

  assign unused_ref_c = ^{fb_refreshBusy, 32'(REFRESH_INTERVAL)};
  assign all_idle_c   = !fb_readBusy && !fb_writeBusy;
`endif

  assign starve_hit_c = hold_valid_q && (starve_q == StarveW'(STARVE_LIMIT));
  assign to_hit_c     = (to_cnt_q == ToW'(TIMEOUT - 1));
  assign mode_ok_c    = (wr_data[35:32] == 4'b1111) || (wr_data[35:32] == 4'b1001);

  // Next-state logic: grant from IDLE, request/busy handshake, per-state timeout.
  always_comb begin
    state_d      = state_q;
    grant_line_c = 1'b0;
    grant_wr_c   = 1'b0;
    line_done_c  = 1'b0;
    wr_done_c    = 1'b0;
    timed_out_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (all_idle_c) begin
`ifdef FB_SCHED_REFRESH_EN
          if (ref_pending_q) begin
            state_d = REF_ISSUE;
          end else
`endif
          if (line_req && !starve_hit_c) begin
            state_d      = LINE_ISSUE;
            grant_line_c = 1'b1;
          end else if (hold_valid_q) begin
            state_d    = WR_ISSUE;
            grant_wr_c = 1'b1;
          end
        end
      end
      LINE_ISSUE: begin
        if (fb_readBusy) begin
          state_d = LINE_WAIT_DONE;
        end else if (to_hit_c) begin
          state_d     = IDLE;
          timed_out_c = 1'b1;
        end
      end
      LINE_WAIT_DONE: begin
        if (!fb_readBusy) begin
          state_d     = IDLE;
          line_done_c = 1'b1;
        end else if (to_hit_c) begin
          state_d     = IDLE;
          timed_out_c = 1'b1;
        end
      end
      WR_ISSUE: begin
        if (fb_writeBusy) begin
          state_d = WR_WAIT_DONE;
        end else if (to_hit_c) begin
          state_d     = IDLE;
          timed_out_c = 1'b1;
          wr_done_c   = 1'b1;
        end
      end
      WR_WAIT_DONE: begin
        if (!fb_writeBusy) begin
          state_d   = IDLE;
          wr_done_c = 1'b1;
        end else if (to_hit_c) begin
          state_d     = IDLE;
          timed_out_c = 1'b1;
          wr_done_c   = 1'b1;
        end
      end
`ifdef FB_SCHED_REFRESH_EN
      REF_ISSUE: begin
        if (fb_refreshBusy) begin
          state_d = REF_WAIT_DONE;
        end else if (to_hit_c) begin
          state_d     = IDLE;
          timed_out_c = 1'b1;
        end
      end
      REF_WAIT_DONE: begin
        if (!fb_refreshBusy) begin
          state_d = IDLE;
        end else if (to_hit_c) begin
          state_d     = IDLE;
          timed_out_c = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: write holding register, starvation and timeout counters, outputs.
  always_comb begin
    hold_valid_d = hold_valid_q;
    wdata_d      = wdata_q;
    wr_drop_d    = 1'b0;
    starve_d     = starve_q;
    to_cnt_d     = to_cnt_q;
    if (wr_done_c) hold_valid_d = 1'b0;
    if (wr_valid && !hold_valid_q) begin
      if (mode_ok_c) begin
        hold_valid_d = 1'b1;
        wdata_d      = wr_data;
      end else begin
        wr_drop_d = 1'b1;
      end
    end
    if (grant_wr_c) begin
      starve_d = '0;
    end else if (grant_line_c && hold_valid_q) begin
      starve_d = starve_q + StarveW'(1);
    end
    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (state_q != IDLE) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
    wr_ready_d    = !hold_valid_d;
    req_line_d    = (state_d == LINE_ISSUE);
    req_wr_d      = (state_d == WR_ISSUE);
    line_ack_d    = line_done_c;
    timeout_err_d = timeout_err_q | timed_out_c;
  end

  // State and datapath registers.
  always_ff @(posedge clk133 or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      hold_valid_q  <= 1'b0;
      wdata_q       <= '0;
      wr_ready_q    <= 1'b1;
      wr_drop_q     <= 1'b0;
      starve_q      <= '0;
      to_cnt_q      <= '0;
      req_line_q    <= 1'b0;
      req_wr_q      <= 1'b0;
      line_ack_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      wdata_q       <= wdata_d;
      wr_ready_q    <= wr_ready_d;
      wr_drop_q     <= wr_drop_d;
      starve_q      <= starve_d;
      to_cnt_q      <= to_cnt_d;
      req_line_q    <= req_line_d;
      req_wr_q      <= req_wr_d;
      line_ack_q    <= line_ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef FB_SCHED_REFRESH_EN
  // Refresh timer: expiry raises a pending refresh; entry to REF_ISSUE consumes it.
  always_comb begin
    ref_expire_c  = (ref_cnt_q == '0);
    ref_cnt_d     = ref_expire_c ? RefW'(REFRESH_INTERVAL - 1) : ref_cnt_q - RefW'(1);
    ref_pending_d = ref_pending_q;
    if (state_q == IDLE && state_d == REF_ISSUE) ref_pending_d = 1'b0;
    if (ref_expire_c) ref_pending_d = 1'b1;
    overdue_d = overdue_q | (ref_expire_c & ref_pending_q);
    req_ref_d = (state_d == REF_ISSUE);
  end

  // Refresh registers.
  always_ff @(posedge clk133 or negedge rstn) begin
    if (!rstn) begin
      ref_cnt_q     <= RefW'(REFRESH_INTERVAL - 1);
      ref_pending_q <= 1'b0;
      overdue_q     <= 1'b0;
      req_ref_q     <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      overdue_q     <= overdue_d;
      req_ref_q     <= req_ref_d;
    end
  end

  assign fb_requestRefresh = req_ref_q;
  assign refresh_overdue   = overdue_q;
`else
  assign fb_requestRefresh = 1'b0;
  assign refresh_overdue   = 1'b0;
`endif

  assign line_ack           = line_ack_q;
  assign wr_ready           = wr_ready_q;
  assign wr_drop            = wr_drop_q;
  assign fb_requestNewLine  = req_line_q;
  assign fb_requestNewWrite = req_wr_q;
  assign fb_writeData       = wdata_q;
  assign timeout_err        = timeout_err_q;

endmodule

// File: tb/tb_fb_access_scheduler.sv
// Directed bench for fb_access_scheduler: frame-buffer responder models, grant scoreboard.
module tb_fb_access_scheduler;

  localparam int unsigned RefInt = 50;
  localparam int unsigned Starve = 4;
  localparam int unsigned To     = 4096;

  logic        clk133 = 1'b0;
  logic        rstn = 1'b0;
  logic        line_req = 1'b0;
  logic        line_ack;
  logic        wr_valid = 1'b0;
  logic [39:0] wr_data = '0;
  logic        wr_ready;
  logic        wr_drop;
  logic        fb_requestNewLine;
  logic        fb_requestNewWrite;
  logic        fb_requestRefresh;
  logic [39:0] fb_writeData;
  logic        fb_readBusy = 1'b0;
  logic        fb_writeBusy = 1'b0;
  logic        fb_refreshBusy = 1'b0;
  logic        refresh_overdue;
  logic        timeout_err;

  int  checks = 0;
  int  errors = 0;
  byte exp_q[$];
  byte got_q[$];
  bit  ref_track = 1'b0;
  int  ack_cnt = 0;
  int  drop_cnt = 0;
  int  wr_grants = 0;
  int  onehot_viol = 0;
  bit  p_line = 1'b0;
  bit  p_wr = 1'b0;
  bit  p_ref = 1'b0;
  bit  rd_en = 1'b1;
  bit  wrm_en = 1'b1;
  bit  rfm_en = 1'b1;
  int  rd_len = 20;
  int  wr_len = 20;
  int  rf_len = 10;

  fb_access_scheduler #(
    .REFRESH_INTERVAL(RefInt),
    .STARVE_LIMIT    (Starve),
    .TIMEOUT         (To)
  ) dut (
    .clk133            (clk133),
    .rstn              (rstn),
    .line_req          (line_req),
    .line_ack          (line_ack),
    .wr_valid          (wr_valid),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .wr_drop           (wr_drop),
    .fb_requestNewLine (fb_requestNewLine),
    .fb_requestNewWrite(fb_requestNewWrite),
    .fb_requestRefresh (fb_requestRefresh),
    .fb_writeData      (fb_writeData),
    .fb_readBusy       (fb_readBusy),
    .fb_writeBusy      (fb_writeBusy),
    .fb_refreshBusy    (fb_refreshBusy),
    .refresh_overdue   (refresh_overdue),
    .timeout_err       (timeout_err)
  );

  always #5 clk133 = ~clk133;

  // Frame-buffer read responder: busy one cycle after the request, held rd_len cycles.
  initial begin
    forever begin
      @(posedge clk133); #1;
      if (rd_en && fb_requestNewLine) begin
        @(posedge clk133); #1 fb_readBusy = 1'b1;
        repeat (rd_len) @(posedge clk133);
        #1 fb_readBusy = 1'b0;
      end
    end
  end

  // Frame-buffer write responder.
  initial begin
    forever begin
      @(posedge clk133); #1;
      if (wrm_en && fb_requestNewWrite) begin
        @(posedge clk133); #1 fb_writeBusy = 1'b1;
        repeat (wr_len) @(posedge clk133);
        #1 fb_writeBusy = 1'b0;
      end
    end
  end

  // Frame-buffer refresh responder.
  initial begin
    forever begin
      @(posedge clk133); #1;
      if (rfm_en && fb_requestRefresh) begin
        @(posedge clk133); #1 fb_refreshBusy = 1'b1;
        repeat (rf_len) @(posedge clk133);
        #1 fb_refreshBusy = 1'b0;
      end
    end
  end

  // Output monitor: records grant order and counts pulses.
  always @(negedge clk133) begin
    if ($countones({fb_requestNewLine, fb_requestNewWrite, fb_requestRefresh}) > 1) onehot_viol++;
    if (line_ack) ack_cnt++;
    if (wr_drop) drop_cnt++;
    if (fb_requestNewLine && !p_line) got_q.push_back("L");
    if (fb_requestNewWrite && !p_wr) begin
      wr_grants++;
      got_q.push_back("W");
    end
    if (fb_requestRefresh && !p_ref && ref_track) got_q.push_back("R");
    p_line = fb_requestNewLine;
    p_wr   = fb_requestNewWrite;
    p_ref  = fb_requestRefresh;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk133); #1;
  endtask

  task automatic do_reset();
    line_req = 1'b0;
    wr_valid = 1'b0;
    step();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
  endtask

  task automatic sb_wait();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 3000) begin
      step();
      n++;
    end
  endtask

  task automatic sb_compare(input string tag);
    byte g;
    byte w;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h2d;
      chk(tag, 64'(g), 64'(w));
    end
    chk({tag, "_missing"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    int a0;
    logic [39:0] d;

    // Reset values
    repeat (3) step();
    chk("rst_outs", 64'({line_ack, wr_drop, fb_requestNewLine, fb_requestNewWrite,
                         fb_requestRefresh, refresh_overdue, timeout_err}), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_wdata", 64'(fb_writeData), 64'd0);
    rstn = 1'b1;

    // Single line fetch: 1-cycle grant latency, drop on busy, one ack
    rd_len = 200;
    a0 = ack_cnt;
    exp_q.push_back("L");
    line_req = 1'b1;
    step();
    chk("line_grant_latency", 64'(fb_requestNewLine), 64'd1);
    n = 0;
    while (!fb_readBusy && n < 50) begin step(); n++; end
    step();
    chk("line_req_dropped", 64'(fb_requestNewLine), 64'd0);
    n = 0;
    while (!line_ack && n < 400) begin step(); n++; end
    chk("line_ack_seen", 64'(line_ack), 64'd1);
    line_req = 1'b0;
    step();
    chk("line_ack_pulse", 64'(line_ack), 64'd0);
    repeat (5) step();
    chk("line_ack_count", 64'(ack_cnt - a0), 64'd1);
    sb_compare("t1_grants");
    rd_len = 20;

    // Unsupported write mode is dropped
    do_reset();
    a0 = drop_cnt;
    n = wr_grants;
    wr_data = 40'hA3_DEAD_BEEF;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("drop_pulse", 64'(wr_drop), 64'd1);
    chk("drop_wr_ready", 64'(wr_ready), 64'd1);
    step();
    chk("drop_pulse_end", 64'(wr_drop), 64'd0);
    repeat (20) step();
    chk("drop_count", 64'(drop_cnt - a0), 64'd1);
    chk("drop_no_write", 64'(wr_grants - n), 64'd0);
    chk("drop_no_capture", 64'(fb_writeData), 64'd0);

    // Valid 1001 write: held data stable through the transfer
    d = 40'h59_0BAD_F00D;
    exp_q.push_back("W");
    wr_data = d;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    chk("wr_accept_ready", 64'(wr_ready), 64'd0);
    chk("wr_accept_nodrop", 64'(wr_drop), 64'd0);
    n = 0;
    while (!fb_requestNewWrite && n < 200) begin step(); n++; end
    chk("wr_data_at_grant", 64'(fb_writeData), 64'(d));
    n = 0;
    while (!fb_writeBusy && n < 50) begin step(); n++; end
    repeat (5) step();
    chk("wr_data_hold", 64'(fb_writeData), 64'(d));
    chk("wr_ready_busy", 64'(wr_ready), 64'd0);
    n = 0;
    while (fb_writeBusy && n < 200) begin step(); n++; end
    repeat (3) step();
    chk("wr_ready_release", 64'(wr_ready), 64'd1);
    sb_compare("t3_grants");

    // Continuous line_req with a pending write: 4 lines, write, lines resume
    do_reset();
    rd_len = 4;
    n = wr_grants;
    exp_q.push_back("L");
    line_req = 1'b1;
    a0 = 0;
    while (!fb_requestNewLine && a0 < 50) begin step(); a0++; end
    wr_data = 40'h1F_CAFE_0001;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    repeat (4) exp_q.push_back("L");
    exp_q.push_back("W");
    exp_q.push_back("L");
    exp_q.push_back("L");
    sb_wait();
    line_req = 1'b0;
    repeat (40) step();
    sb_compare("starve_order");
    chk("starve_wr_count", 64'(wr_grants - n), 64'd1);
    chk("starve_wr_ready", 64'(wr_ready), 64'd1);
    rd_len = 20;

    // Line timeout: no busy response, error after TIMEOUT cycles, no ack
    do_reset();
    rd_en = 1'b0;
    a0 = ack_cnt;
    exp_q.push_back("L");
    line_req = 1'b1;
    n = 0;
    while (!fb_requestNewLine && n < 50) begin step(); n++; end
    n = 0;
    while (!timeout_err && n < 5000) begin step(); n++; end
    line_req = 1'b0;
    chk("line_timeout_cycles", 64'(n), 64'(To));
    chk("line_timeout_req", 64'(fb_requestNewLine), 64'd0);
    repeat (5) step();
    chk("line_timeout_noack", 64'(ack_cnt - a0), 64'd0);
    chk("timeout_sticky", 64'(timeout_err), 64'd1);
    sb_compare("t5_grants");
    rd_en = 1'b1;

    // Reset during WR_WAIT_DONE: requests drop, no grant until writeBusy falls
    do_reset();
    chk("timeout_cleared", 64'(timeout_err), 64'd0);
    wr_len = 100;
    exp_q.push_back("W");
    wr_data = 40'h2F_1111_2222;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    n = 0;
    while (!fb_writeBusy && n < 200) begin step(); n++; end
    repeat (3) step();
    rstn = 1'b0;
    #1;
    chk("midrst_reqs", 64'({fb_requestNewLine, fb_requestNewWrite, fb_requestRefresh}), 64'd0);
    chk("midrst_wr_ready", 64'(wr_ready), 64'd1);
    step();
    rstn = 1'b1;
    exp_q.push_back("L");
    line_req = 1'b1;
    n = 0;
    while (!fb_requestNewLine && n < 300) begin step(); n++; end
    chk("midrst_line_grant", 64'(fb_requestNewLine), 64'd1);
    chk("midrst_wait_busy", 64'(fb_writeBusy), 64'd0);
    n = 0;
    while (!line_ack && n < 300) begin step(); n++; end
    line_req = 1'b0;
    repeat (5) step();
    sb_compare("midrst_grants");
    wr_len = 20;

`ifdef FB_SCHED_REFRESH_EN
    // Refresh expiry coinciding with line_req: refresh first, then line
    do_reset();
    ref_track = 1'b1;
    repeat (RefInt) @(posedge clk133);
    #1;
    exp_q.push_back("R");
    exp_q.push_back("L");
    line_req = 1'b1;
    sb_wait();
    ref_track = 1'b0;
    n = 0;
    while (!line_ack && n < 300) begin step(); n++; end
    line_req = 1'b0;
    sb_compare("ref_priority");

    // Refresh busy stuck low: timeout, back to IDLE, overdue set
    do_reset();
    rfm_en = 1'b0;
    n = 0;
    while (!timeout_err && n < 6000) begin step(); n++; end
    chk("ref_timeout", 64'(timeout_err), 64'd1);
    chk("ref_timeout_req", 64'(fb_requestRefresh), 64'd0);
    chk("ref_overdue", 64'(refresh_overdue), 64'd1);
    do_reset();
    rfm_en = 1'b1;
    chk("ref_overdue_cleared", 64'(refresh_overdue), 64'd0);
`endif

    repeat (5) step();
    chk("one_request_at_a_time", 64'(onehot_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
